ccw_sequencer: RTL and testbench

CCW_SEQUENCER -- requirements
Module: ccw_sequencer

---
 rtl/channel_pkg.sv | 19 +
 rtl/ccw_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ccw_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_pkg.sv
// Shared channel definitions: sequencer state encoding and channel command bytes.
package channel_pkg;

    // Sequencer states, in the order an operation walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_ACTIVE,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_DONE
    } ccw_state_t;

    // Channel command bytes.
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'h03;

endpackage

// File: rtl/ccw_sequencer.sv
// Channel command sequencer: accepts one request, starts the channel, moves
// up to req_count bytes between host and channel streams, stops or observes
// the channel ending, then reports done with the unused count in residual.
// Optional feature macro: CCW_SKIP_EN (read data discard via req_skip).
module ccw_sequencer
    import channel_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             req_addr,
    input  logic [7:0]             req_command,
    input  logic [COUNT_WIDTH-1:0] req_count,
    input  logic                   req_skip,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [7:0]             ch_addr,
    output logic [7:0]             ch_command,
    output logic                   ch_start,
    output logic                   ch_stop,
    input  logic                   ch_active,
    output logic [7:0]             ch_send_tdata,
    output logic                   ch_send_tvalid,
    input  logic                   ch_send_tready,
    input  logic [7:0]             ch_recv_tdata,
    input  logic                   ch_recv_tvalid,
    output logic                   ch_recv_tready,
    input  logic [7:0]             host_send_tdata,
    input  logic                   host_send_tvalid,
    output logic                   host_send_tready,
    output logic [7:0]             host_recv_tdata,
    output logic                   host_recv_tvalid,
    input  logic                   host_recv_tready,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] residual
);

    localparam int unsigned TIMER_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);

    ccw_state_t             state;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [TIMER_W-1:0]     timer;
    logic                   xfer_on;
    logic                   send_hs;
    logic                   recv_hs;
    logic [1:0]             dec;
    logic                   skip;

`ifndef CCW_SKIP_EN
    logic unused_skip;
    assign skip        = 1'b0;
    assign unused_skip = req_skip;
`endif

    assign req_ready       = (state == ST_IDLE);
    assign xfer_on         = (state == ST_XFER) && (count != '0);
    assign ch_send_tdata   = host_send_tdata;
    assign host_recv_tdata = ch_recv_tdata;

    // Data path gating: streams pass through only while transferring with count left.
    always_comb begin
        ch_send_tvalid   = 1'b0;
        host_send_tready = 1'b0;
        host_recv_tvalid = 1'b0;
        ch_recv_tready   = 1'b0;
        if (xfer_on) begin
            ch_send_tvalid   = host_send_tvalid;
            host_send_tready = ch_send_tready;
            if (skip) begin
                ch_recv_tready = 1'b1;
            end else begin
                host_recv_tvalid = ch_recv_tvalid;
                ch_recv_tready   = host_recv_tready;
            end
        end
    end

    // Count after this cycle's handshakes, saturating at zero.
    always_comb begin
        send_hs    = ch_send_tvalid && ch_send_tready;
        recv_hs    = ch_recv_tvalid && ch_recv_tready;
        dec        = {1'b0, send_hs} + {1'b0, recv_hs};
        count_next = (count > COUNT_WIDTH'(dec)) ? count - COUNT_WIDTH'(dec) : '0;
    end

    // Sequencer FSM with registered pulses and latched request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            timer      <= '0;
            ch_addr    <= '0;
            ch_command <= '0;
            ch_start   <= 1'b0;
            ch_stop    <= 1'b0;
            done       <= 1'b0;
            residual   <= '0;
`ifdef CCW_SKIP_EN
            skip       <= 1'b0;
`endif
        end else begin
            ch_start <= 1'b0;
            ch_stop  <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        ch_addr    <= req_addr;
                        ch_command <= req_command;
                        count      <= req_count;
`ifdef CCW_SKIP_EN
                        skip       <= req_skip;
`endif
                        ch_start   <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    timer <= '0;
                    state <= ST_WAIT_ACTIVE;
                end
                ST_WAIT_ACTIVE: begin
                    if (ch_active) begin
                        state <= ST_XFER;
                    end else if (timer == TIMER_LAST) begin
                        residual <= count;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_XFER: begin
                    count <= count_next;
                    // A channel dropping active wins over a pending stop request.
                    if (!ch_active) begin
                        residual <= count_next;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else if ((count == '0) && (ch_send_tready || ch_recv_tvalid)) begin
                        ch_stop <= 1'b1;
                        state   <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!ch_active) begin
                        residual <= count;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccw_sequencer.sv
// Self-checking bench for ccw_sequencer with a behavioural channel/host model.
// Honours CCW_SKIP_EN the same way as the design.
module tb_ccw_sequencer;
    import channel_pkg::*;

    localparam int unsigned CW = 16;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    req_addr, req_command;
    logic [CW-1:0] req_count;
    logic          req_skip, req_valid, req_ready;
    logic [7:0]    ch_addr, ch_command;
    logic          ch_start, ch_stop, ch_active;
    logic [7:0]    ch_send_tdata;
    logic          ch_send_tvalid, ch_send_tready;
    logic [7:0]    ch_recv_tdata;
    logic          ch_recv_tvalid, ch_recv_tready;
    logic [7:0]    host_send_tdata;
    logic          host_send_tvalid, host_send_tready;
    logic [7:0]    host_recv_tdata;
    logic          host_recv_tvalid, host_recv_tready;
    logic          done;
    logic [CW-1:0] residual;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Observations gathered by run_op.
    bit          r_done;
    int unsigned r_cycles, r_res, r_stops, r_starts, r_leak, r_xfers, r_host_rvalid, r_done_pulses;
    logic [7:0]  r_addr, r_cmd;
    logic [7:0]  cu_sent[$], host_got[$], host_sent[$], cu_got[$];

    ccw_sequencer #(.COUNT_WIDTH(CW), .START_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_command(req_command), .req_count(req_count),
        .req_skip(req_skip), .req_valid(req_valid), .req_ready(req_ready),
        .ch_addr(ch_addr), .ch_command(ch_command), .ch_start(ch_start),
        .ch_stop(ch_stop), .ch_active(ch_active),
        .ch_send_tdata(ch_send_tdata), .ch_send_tvalid(ch_send_tvalid), .ch_send_tready(ch_send_tready),
        .ch_recv_tdata(ch_recv_tdata), .ch_recv_tvalid(ch_recv_tvalid), .ch_recv_tready(ch_recv_tready),
        .host_send_tdata(host_send_tdata), .host_send_tvalid(host_send_tvalid), .host_send_tready(host_send_tready),
        .host_recv_tdata(host_recv_tdata), .host_recv_tvalid(host_recv_tvalid), .host_recv_tready(host_recv_tready),
        .done(done), .residual(residual)
    );

    always #5 clk = ~clk;

`ifdef CCW_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // Reference: a CU moving cu_bytes bytes against a count of n. Modes: 0 no CU, 1 read, 2 write.
    function automatic void model(input int unsigned n, input int unsigned mode, input int unsigned cu_bytes,
                                  output int unsigned x, output int unsigned stops, output int unsigned res);
        x     = (mode == 0) ? 0 : ((cu_bytes < n) ? cu_bytes : n);
        stops = (mode != 0 && cu_bytes > n) ? 1 : 0;
        res   = n - x;
    endfunction

    function automatic int unsigned qdiff(input logic [7:0] a[$], input logic [7:0] b[$]);
        int unsigned d;
        d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) d++;
        return d;
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0; req_addr = '0; req_command = '0; req_count = '0; req_skip = 1'b0;
        ch_active = 1'b0; ch_send_tready = 1'b0; ch_recv_tvalid = 1'b0; ch_recv_tdata = '0;
        host_send_tvalid = 1'b0; host_send_tdata = '0; host_recv_tready = 1'b0;
    endtask

    // Issue one request and play channel + host until done, bounded by a cycle budget.
    task automatic run_op(input logic [7:0] a, input logic [7:0] c, input int unsigned n,
                          input logic sk, input int unsigned mode, input int unsigned cu_bytes);
        bit acc_now, saw_start, ended, finished, prev_act, stop_now;
        bit s_chs, s_hhs, r_chs, r_hhs;
        int unsigned cyc;
        r_done = 0; r_cycles = 0; r_res = 0; r_stops = 0; r_starts = 0; r_leak = 0;
        r_xfers = 0; r_host_rvalid = 0; r_done_pulses = 0; r_addr = '0; r_cmd = '0;
        cu_sent.delete(); host_got.delete(); host_sent.delete(); cu_got.delete();
        saw_start = 0; ended = 0; finished = 0; prev_act = 0;
        @(posedge clk); #1;
        req_addr = a; req_command = c; req_count = CW'(n); req_skip = sk; req_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 800 && !finished; i++) begin
            @(negedge clk);
            acc_now  = req_valid && req_ready;
            stop_now = ch_stop;
            if (ch_start) begin r_starts++; r_addr = ch_addr; r_cmd = ch_command; saw_start = 1; end
            if (ch_stop) r_stops++;
            if (done) begin
                r_done_pulses++;
                if (!r_done) begin r_done = 1; r_cycles = cyc; r_res = residual; end
            end
            if (!ch_active && !prev_act &&
                (ch_send_tvalid || host_send_tready || host_recv_tvalid || ch_recv_tready)) r_leak++;
            prev_act = ch_active;
            if (host_recv_tvalid) r_host_rvalid++;
            s_chs = ch_send_tvalid && ch_send_tready;
            s_hhs = host_send_tvalid && host_send_tready;
            r_chs = ch_recv_tvalid && ch_recv_tready;
            r_hhs = host_recv_tvalid && host_recv_tready;
            if (s_chs) begin cu_got.push_back(ch_send_tdata); r_xfers++; end
            if (s_hhs) host_sent.push_back(host_send_tdata);
            if (r_chs) begin cu_sent.push_back(ch_recv_tdata); r_xfers++; end
            if (r_hhs) host_got.push_back(host_recv_tdata);
            @(posedge clk); #1;
            cyc++;
            if (acc_now) req_valid = 1'b0;
            if (r_done && cyc >= r_cycles + 3) finished = 1;
            if (ch_active) begin
                if (stop_now || r_xfers >= cu_bytes) begin ch_active = 1'b0; ended = 1; end
            end else if (saw_start && !ended && mode != 0) begin
                ch_active = 1'b1;
            end
            if (ch_active && mode == 1 && r_xfers < cu_bytes) begin
                if (!ch_recv_tvalid || r_chs) begin
                    ch_recv_tvalid = ($urandom_range(0, 3) != 0);
                    ch_recv_tdata  = 8'($urandom);
                end
            end else begin
                ch_recv_tvalid = 1'b0;
            end
            ch_send_tready   = ch_active && mode == 2 && r_xfers < cu_bytes && ($urandom_range(0, 3) != 0);
            host_recv_tready = ($urandom_range(0, 3) != 0);
            if (!host_send_tvalid || s_hhs) begin
                host_send_tvalid = ($urandom_range(0, 2) != 0);
                host_send_tdata  = 8'($urandom);
            end
        end
        idle_inputs();
        if (!r_done) begin
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ch_start, ch_stop, done, ch_send_tvalid, host_send_tready, host_recv_tvalid, ch_recv_tready} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {ch_start, ch_stop, done, ch_send_tvalid, host_send_tready, host_recv_tvalid, ch_recv_tready});
        end
        n_checks++;
        if ({ch_addr, ch_command, residual} !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0", {ch_addr, ch_command, residual});
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_read();
        int unsigned ex, es, er;
        model(6, 1, 16, ex, es, er);
        run_op(8'h1a, CMD_READ, 6, 1'b0, 1, 16);
        n_checks++;
        if (r_done !== 1'b1 || r_done_pulses != 1) begin
            n_fail++; $display("FAIL read_done: got %0d pulses expected 1", r_done_pulses);
        end
        n_checks++;
        if (r_starts != 1 || r_addr !== 8'h1a || r_cmd !== CMD_READ) begin
            n_fail++; $display("FAIL read_start: got %0d/%h/%h expected 1/1a/02", r_starts, r_addr, r_cmd);
        end
        n_checks++;
        if (r_xfers != ex) begin n_fail++; $display("FAIL read_bytes: got %0d expected %0d", r_xfers, ex); end
        n_checks++;
        if (host_got.size() != ex || qdiff(host_got, cu_sent) != 0) begin
            n_fail++; $display("FAIL read_data: got %0d host bytes expected %0d matching", host_got.size(), ex);
        end
        n_checks++;
        if (r_stops != es) begin n_fail++; $display("FAIL read_stop: got %0d expected %0d", r_stops, es); end
        n_checks++;
        if (r_res != er) begin n_fail++; $display("FAIL read_residual: got %0d expected %0d", r_res, er); end
        n_checks++;
        if (r_leak != 0) begin n_fail++; $display("FAIL read_idle_gating: got %0d expected 0", r_leak); end
    endtask

    task automatic test_write();
        int unsigned ex, es, er;
        model(16, 2, 6, ex, es, er);
        run_op(8'h22, CMD_WRITE, 16, 1'b0, 2, 6);
        n_checks++;
        if (r_xfers != ex) begin n_fail++; $display("FAIL write_bytes: got %0d expected %0d", r_xfers, ex); end
        n_checks++;
        if (cu_got.size() != ex || qdiff(cu_got, host_sent) != 0) begin
            n_fail++; $display("FAIL write_data: got %0d cu bytes expected %0d matching", cu_got.size(), ex);
        end
        n_checks++;
        if (r_stops != es) begin n_fail++; $display("FAIL write_stop: got %0d expected %0d", r_stops, es); end
        n_checks++;
        if (r_res != er) begin n_fail++; $display("FAIL write_residual: got %0d expected %0d", r_res, er); end
    endtask

    task automatic test_no_cu();
        run_op(8'h10, CMD_READ, 9, 1'b0, 0, 0);
        // Cycle 0 is the request cycle; start, TO wait cycles, then done.
        n_checks++;
        if (r_done !== 1'b1 || r_cycles != TO + 2) begin
            n_fail++; $display("FAIL nocu_timing: got done=%0d at cycle %0d expected cycle %0d", r_done, r_cycles, TO + 2);
        end
        n_checks++;
        if (r_res != 9 || r_stops != 0) begin
            n_fail++; $display("FAIL nocu_residual: got %0d stops %0d expected 9 stops 0", r_res, r_stops);
        end
    endtask

    task automatic test_nop();
        run_op(8'h05, CMD_NOP, 0, 1'b0, 2, 16);
        n_checks++;
        if (r_stops != 1 || r_xfers != 0) begin
            n_fail++; $display("FAIL nop_stop: got stops %0d bytes %0d expected 1 0", r_stops, r_xfers);
        end
        n_checks++;
        if (r_done !== 1'b1 || r_res != 0) begin
            n_fail++; $display("FAIL nop_done: got done %0d residual %0d expected 1 0", r_done, r_res);
        end
    endtask

    task automatic test_busy();
        run_op(8'h33, CMD_READ, 6, 1'b0, 1, 0);
        n_checks++;
        if (r_done !== 1'b1 || r_res != 6 || r_stops != 0) begin
            n_fail++; $display("FAIL busy: got done %0d residual %0d stops %0d expected 1 6 0", r_done, r_res, r_stops);
        end
    endtask

    task automatic test_reset_abort();
        int unsigned bad;
        @(posedge clk); #1;
        req_addr = 8'h2b; req_command = CMD_READ; req_count = CW'(10); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ch_start !== 1'b1 || ch_addr !== 8'h2b) begin
            n_fail++; $display("FAIL abort_start: got %b/%h expected 1/2b", ch_start, ch_addr);
        end
        @(posedge clk); #1;
        ch_active = 1'b1; ch_recv_tvalid = 1'b1; ch_recv_tdata = 8'h5a; host_recv_tready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (host_recv_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL abort_xfer: got %b expected 1", host_recv_tvalid);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({ch_start, ch_stop, done, ch_send_tvalid, host_send_tready, host_recv_tvalid, ch_recv_tready,
             ch_addr, ch_command, residual} !== 39'h0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_outputs: got %h ready %b expected 0 ready 1",
                {ch_start, ch_stop, done, ch_send_tvalid, host_send_tready, host_recv_tvalid, ch_recv_tready,
                 ch_addr, ch_command, residual}, req_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ch_stop || done || ch_start || host_recv_tvalid || ch_recv_tready || !req_ready) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad); end
        idle_inputs();
        @(posedge clk);
    endtask

    task automatic test_skip();
        int unsigned ex, es, er;
        model(4, 1, 16, ex, es, er);
        run_op(8'h1a, CMD_READ, 4, 1'b1, 1, 16);
        n_checks++;
        if (r_xfers != ex || r_res != er || r_stops != es) begin
            n_fail++; $display("FAIL skip_count: got %0d/%0d/%0d expected %0d/%0d/%0d", r_xfers, r_res, r_stops, ex, er, es);
        end
        n_checks++;
        if (SKIP_EN) begin
            if (r_host_rvalid != 0 || host_got.size() != 0) begin
                n_fail++; $display("FAIL skip_host: got %0d valid cycles expected 0", r_host_rvalid);
            end
        end else begin
            if (host_got.size() != ex || qdiff(host_got, cu_sent) != 0) begin
                n_fail++; $display("FAIL skip_ignored: got %0d host bytes expected %0d", host_got.size(), ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned n, mode, cb, ex, es, er, derr;
        logic sk;
        for (int k = 0; k < 12; k++) begin
            n    = $urandom_range(0, 20);
            cb   = $urandom_range(0, 24);
            mode = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 2);
            sk   = 1'($urandom_range(0, 1));
            model(n, mode, cb, ex, es, er);
            run_op(8'($urandom), (mode == 2) ? CMD_WRITE : CMD_READ, n, sk, mode, cb);
            n_checks++;
            if (r_done !== 1'b1 || r_res != er || r_stops != es || r_xfers != ex) begin
                n_fail++; $display("FAIL b2b_%0d: got res %0d stop %0d bytes %0d expected %0d %0d %0d",
                    k, r_res, r_stops, r_xfers, er, es, ex);
            end
            derr = 0;
            if (mode == 0 && r_cycles != TO + 2) derr++;
            if (mode == 1 && !(SKIP_EN && sk) && qdiff(host_got, cu_sent) != 0) derr++;
            if (mode == 1 && SKIP_EN && sk && host_got.size() != 0) derr++;
            if (mode == 2 && qdiff(cu_got, host_sent) != 0) derr++;
            if (r_leak != 0 || r_done_pulses != 1) derr++;
            n_checks++;
            if (derr != 0) begin n_fail++; $display("FAIL b2b_detail_%0d: got %0d errors expected 0", k, derr); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_no_cu();
        test_nop();
        test_busy();
        test_reset_abort();
        test_skip();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
